regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32-entry register file among NUM_REQ requesters, e.g. processor writeback, Morse decode unit and I/O capture.
- Selects one writer per cycle and registers the chosen address, data and enable.
- The registered 5-bit address drives the register file's 5-to-32 write decoder; the enable gates the decoder outputs.
- Port 0 has fixed priority. Ports 1..NUM_REQ-1 are served round-robin.
- A starvation guard bounds how long any lower port can wait.

---
 rtl/regfile_write_arbiter_pkg.sv | 15 +
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter_rr_pick.sv | 23 ++
 rtl/regfile_write_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
`ifndef REGFILE_WRITE_ARBITER_PKG_SV
`define REGFILE_WRITE_ARBITER_PKG_SV
package regfile_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned REG_COUNT        = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int unsigned MAX_WAIT_DEFAULT = 8;
    localparam int unsigned NUM_REQ_DEFAULT  = 4;
    localparam int unsigned DATA_W_DEFAULT   = 32;

endpackage
`endif

// File: rtl/regfile_write_arbiter_if.sv
// Requester bus plus the registered register-file write port.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0]     req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wr_en;
    logic [REG_ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]             wr_data;
    logic                          starve_evt;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, starve_evt
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, starve_evt
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid bit at or after i_ptr, wrapping.
module regfile_write_arbiter_rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_pick,
    output logic             o_any
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_rot_pick;

    // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        w_rot      = N'({i_valid, i_valid} >> i_ptr);
        w_rot_pick = w_rot & (~w_rot + N'(1));
        o_pick     = N'({w_rot_pick, w_rot_pick} >> (N - i_ptr));
        o_any      = |i_valid;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: port 0 priority, round-robin for the rest,
// with a starvation override and a registered write port.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEFAULT,
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(REG_COUNT);
    localparam int unsigned NLOW   = NUM_REQ - 1;
    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [PTR_W-1:0]  r_ptr;
    logic [WAIT_W-1:0] r_wait [1:NUM_REQ-1];
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_starve;

    logic [NLOW-1:0]    w_rr_pick;
    logic               w_rr_any;
    logic [PTR_W-1:0]   w_rr_ptr;
    logic               w_ovr;
    logic [PTR_W-1:0]   w_ovr_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_xfer;
    logic [PTR_W-1:0]   w_sel;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;

    assign w_rr_ptr = r_ptr - PTR_W'(1);

    regfile_write_arbiter_rr_pick #(
        .N     (NLOW),
        .IDX_W (PTR_W)
    ) u_rr_pick (
        .i_valid (bus.req_valid[NUM_REQ-1:1]),
        .i_ptr   (w_rr_ptr),
        .o_pick  (w_rr_pick),
        .o_any   (w_rr_any)
    );

    // Lowest-indexed low-priority port that has waited MAX_WAIT cycles.
    always_comb begin
        w_ovr     = 1'b0;
        w_ovr_idx = '0;
        for (int k = 1; k < int'(NUM_REQ); k++) begin
            if (!w_ovr && bus.req_valid[k] && (r_wait[k] == WAIT_W'(MAX_WAIT))) begin
                w_ovr     = 1'b1;
                w_ovr_idx = PTR_W'(k);
            end
        end
    end

    // Grant priority: override, then port 0, then round-robin; nothing in reset.
    always_comb begin
        w_grant = '0;
        if (!reset_n) begin
            w_grant = '0;
        end else if (w_ovr) begin
            w_grant[w_ovr_idx] = 1'b1;
        end else if (bus.req_valid[0]) begin
            w_grant[0] = 1'b1;
        end else if (w_rr_any) begin
            w_grant = {w_rr_pick, 1'b0};
        end
    end

    assign bus.req_ready = w_grant;

    // Steer the granted port's address and data onto the write path.
    always_comb begin
        w_xfer     = |w_grant;
        w_sel      = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_grant[i]) begin
                w_sel      = PTR_W'(i);
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Per-port wait counters: count while pending, saturate, clear on grant or withdrawal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k < int'(NUM_REQ); k++) r_wait[k] <= '0;
        end else begin
            for (int k = 1; k < int'(NUM_REQ); k++) begin
                if (!bus.req_valid[k] || w_grant[k]) begin
                    r_wait[k] <= '0;
                end else if (r_wait[k] != WAIT_W'(MAX_WAIT)) begin
                    r_wait[k] <= r_wait[k] + WAIT_W'(1);
                end
            end
        end
    end

    // Round-robin pointer moves past each served low-priority port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= PTR_W'(1);
        end else if (w_xfer && (w_sel != '0)) begin
            r_ptr <= (w_sel == PTR_W'(NLOW)) ? PTR_W'(1) : w_sel + PTR_W'(1);
        end
    end

    // Write port register; register zero is never written but the select still follows.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_starve  <= 1'b0;
        end else begin
            r_wr_en  <= w_xfer && (w_sel_addr != REG_ZERO);
            r_starve <= w_ovr;
            if (w_xfer) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.starve_evt = r_starve;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised scoreboard bench for regfile_write_arbiter with directed scenarios.
module tb_regfile_write_arbiter;

    localparam int NR = 4;
    localparam int MW = 8;

    logic clock;
    logic reset_n;

    regfile_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(32)) bus ();

    regfile_write_arbiter #(.NUM_REQ(NR), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          edge_no;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        starve;
    } rec_t;

    rec_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    logic [NR-1:0] tv_valid;
    logic [4:0]    tv_addr [NR];
    logic [31:0]   tv_data [NR];
    logic [NR-1:0] last_ready;

    int m_ptr;
    int m_wait [NR];

    logic [4:0]  mon_last_addr = '0;
    logic [31:0] mon_last_data = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 1;
        for (int i = 0; i < NR; i++) m_wait[i] = 0;
    endtask

    // Grant as stated by the rules: starving port, then port 0, then rotation from pointer.
    task automatic model_pick(output int g, output bit ovr);
        g   = -1;
        ovr = 1'b0;
        for (int k = 1; k < NR; k++) begin
            if (g < 0 && tv_valid[k] && m_wait[k] == MW) begin
                g   = k;
                ovr = 1'b1;
            end
        end
        if (g < 0 && tv_valid[0]) g = 0;
        for (int s = 0; s < NR - 1; s++) begin
            int k;
            k = 1 + ((m_ptr - 1 + s) % (NR - 1));
            if (g < 0 && tv_valid[k]) g = k;
        end
    endtask

    task automatic model_update(input int g);
        for (int k = 1; k < NR; k++) begin
            if (!tv_valid[k] || k == g) m_wait[k] = 0;
            else if (m_wait[k] < MW) m_wait[k] = m_wait[k] + 1;
        end
        if (g >= 1) m_ptr = (g == NR - 1) ? 1 : g + 1;
    endtask

    // Drive one cycle of requests, check the grant and queue the expected write.
    task automatic step();
        int            g;
        bit            ovr;
        logic [NR-1:0] exp_ready;
        rec_t          r;
        @(negedge clock);
        bus.req_valid = tv_valid;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*5 +: 5]   = tv_addr[i];
            bus.req_data[i*32 +: 32] = tv_data[i];
        end
        #1;
        model_pick(g, ovr);
        exp_ready = (g >= 0) ? NR'(1 << g) : '0;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        if (g >= 0) begin
            r.edge_no = edge_cnt + 1;
            r.en      = (tv_addr[g] != 5'd0);
            r.addr    = tv_addr[g];
            r.data    = tv_data[g];
            r.starve  = ovr;
            q.push_back(r);
        end
        model_update(g);
        last_ready = bus.req_ready;
    endtask

    // Monitor: after each edge, compare against the queued write or expect an idle port.
    always @(posedge clock) begin
        rec_t r;
        #1;
        if (q.size() > 0 && q[0].edge_no == edge_cnt) begin
            r = q.pop_front();
            chk("wr_en",      64'(bus.wr_en),      64'(r.en));
            chk("wr_addr",    64'(bus.wr_addr),    64'(r.addr));
            chk("wr_data",    64'(bus.wr_data),    64'(r.data));
            chk("starve_evt", 64'(bus.starve_evt), 64'(r.starve));
            mon_last_addr = r.addr;
            mon_last_data = r.data;
        end else begin
            chk("idle_wr_en",   64'(bus.wr_en),      64'(0));
            chk("idle_starve",  64'(bus.starve_evt), 64'(0));
            chk("hold_wr_addr", 64'(bus.wr_addr),    64'(mon_last_addr));
            chk("hold_wr_data", 64'(bus.wr_data),    64'(mon_last_data));
        end
    end

    initial begin
        int n_starve;
        reset_n       = 1'b0;
        tv_valid      = '0;
        last_ready    = '0;
        for (int i = 0; i < NR; i++) begin
            tv_addr[i] = 5'(i + 1);
            tv_data[i] = 32'h1000 + 32'(i);
        end
        bus.req_valid = '1;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        model_reset();
        #3;
        chk("reset_ready",  64'(bus.req_ready),  64'(0));
        chk("reset_wr_en",  64'(bus.wr_en),      64'(0));
        chk("reset_starve", 64'(bus.starve_evt), 64'(0));
        bus.req_valid = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset
        repeat (5) step();

        // Port 0 and port 2 together: port 0 first, port 2 next
        tv_valid   = 4'b0101;
        tv_addr[0] = 5'd3;  tv_data[0] = 32'hDEADBEEF;
        tv_addr[2] = 5'd7;  tv_data[2] = 32'h0000_0777;
        step();
        chk("p0_first", 64'(last_ready), 64'(4'b0001));
        tv_valid[0] = 1'b0;
        step();
        chk("p2_next", 64'(last_ready), 64'(4'b0100));
        tv_valid = '0;
        step();

        // Round-robin among ports 1..3
        tv_valid = 4'b1110;
        tv_addr[1] = 5'd11; tv_data[1] = 32'hA1;
        tv_addr[2] = 5'd12; tv_data[2] = 32'hA2;
        tv_addr[3] = 5'd13; tv_data[3] = 32'hA3;
        step();
        chk("rr_after_p2", 64'(last_ready), 64'(4'b1000));
        repeat (5) step();
        tv_valid = '0;
        step();

        // Starvation: port 0 always busy, port 3 waiting
        tv_valid   = 4'b1001;
        tv_addr[3] = 5'd21; tv_data[3] = 32'hBADC0DE;
        n_starve   = 0;
        for (int n = 1; n <= 20; n++) begin
            tv_addr[0] = 5'(n); tv_data[0] = 32'(n * 3);
            step();
            if (n_starve == 0 && last_ready[3]) n_starve = n;
        end
        chk("starve_cycle", 64'(n_starve), 64'(9));
        tv_valid = '0;
        step();

        // Register-zero write from port 1, then pointer sits at port 2
        tv_valid   = 4'b0010;
        tv_addr[1] = 5'd0; tv_data[1] = 32'h1234;
        step();
        chk("zero_ready", 64'(last_ready), 64'(4'b0010));
        tv_valid   = 4'b1110;
        tv_addr[1] = 5'd11;
        step();
        chk("ptr_after_zero", 64'(last_ready), 64'(4'b0100));
        tv_valid = '0;
        step();

        // Asynchronous reset while a write is presented
        tv_valid   = 4'b0010;
        tv_addr[1] = 5'd9; tv_data[1] = 32'h99;
        step();
        tv_valid = '0;
        @(posedge clock);
        #2;
        chk("pre_reset_wr_en", 64'(bus.wr_en), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("async_wr_en",  64'(bus.wr_en),     64'(0));
        chk("async_ready",  64'(bus.req_ready), 64'(0));
        chk("async_addr",   64'(bus.wr_addr),   64'(0));
        q.delete();
        model_reset();
        mon_last_addr = '0;
        mon_last_data = '0;
        bus.req_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        tv_valid   = 4'b0110;
        tv_addr[1] = 5'd14; tv_addr[2] = 5'd15;
        step();
        chk("post_reset_p1", 64'(last_ready), 64'(4'b0010));
        tv_valid = '0;
        step();

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (tv_valid[i]) begin
                    if (i > 0 && $urandom_range(0, 15) == 0) tv_valid[i] = 1'b0;
                end else if ($urandom_range(0, 99) < ((i == 0) ? 70 : 40)) begin
                    tv_valid[i] = 1'b1;
                    tv_addr[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    tv_data[i]  = $urandom;
                end
            end
            step();
            for (int i = 0; i < NR; i++) if (last_ready[i]) tv_valid[i] = 1'b0;
        end

        tv_valid = '0;
        repeat (3) step();
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
